// File: rtl/debounce_bank.sv
// N-channel debouncer: a level is accepted once it has held for STABLE_CYCLES clocks, with rise/fall strobes.
// Optional DEBOUNCE_BANK_SYNC_EN adds a 2-flop synchroniser per input bit ahead of the filter.
module debounce_bank #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] bouncey_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic            busy_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("debounce_bank: STABLE_CYCLES must be >= 2");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_bank: N_CH must be >= 1");
  end

  logic [N_CH-1:0]  in_s;
  logic [N_CH-1:0]  prev_q, prev_d;
  logic [N_CH-1:0]  clean_d, rise_d, fall_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

`ifdef DEBOUNCE_BANK_SYNC_EN
  logic [N_CH-1:0] sync_q1, sync_q2;

  // Metastability guard for pins that are asynchronous to clk_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q1 <= {N_CH{RESET_VAL}};
      sync_q2 <= {N_CH{RESET_VAL}};
    end else begin
      sync_q1 <= bouncey_in;
      sync_q2 <= sync_q1;
    end
  end

  assign in_s = sync_q2;
`else
  assign in_s = bouncey_in;
`endif

  // Per-channel settle counter: any bounce or agreement with the clean level restarts it.
  always_comb begin
    prev_d  = in_s;
    clean_d = clean_out;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if ((in_s[i] == prev_q[i]) && (in_s[i] != clean_out[i])) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = in_s[i];
          rise_d[i]  = in_s[i];
          fall_d[i]  = ~in_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      prev_q    <= {N_CH{RESET_VAL}};
      clean_out <= {N_CH{RESET_VAL}};
      rise_out  <= '0;
      fall_out  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      prev_q    <= prev_d;
      clean_out <= clean_d;
      rise_out  <= rise_d;
      fall_out  <= fall_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Settle-in-progress indicator, derived only from the counter registers.
  always_comb begin
    busy_out = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      busy_out = busy_out | (cnt_q[i] != '0);
    end
  end

endmodule
